btb_update_ctrl: RTL and testbench

BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

---
 rtl/btb_pkg.sv | 28 ++
 rtl/btb_upd_fifo.sv | 60 ++++++
 rtl/btb_update_ctrl.sv | 157 +++++++++++++++
 tb/tb_btb_update_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared widths, FSM encoding and 2-bit counter encodings for the BTB update path.
package btb_pkg;

  localparam int WORD_SIZE = 16;
  localparam int IDX_BITS  = 8;
  localparam int TAG_BITS  = WORD_SIZE - IDX_BITS;
  localparam int QDEPTH    = 4;

  // INIT  : power-on invalidate sweep
  // RUN   : draining queued updates into the BTB
  // FLUSH : invalidate sweep requested by flush_req
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Both sweep states write invalid entries and block new requests.
  function automatic logic is_sweep_state(input state_e s);
    return (s == ST_INIT) || (s == ST_FLUSH);
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Update queue: up to two pushes and one pop per cycle, synchronous clear.
// The caller never pushes slot 1 without slot 0 and never overfills.
module btb_upd_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             wr0_en,
  input  logic [WIDTH-1:0] wr0_data,
  input  logic             wr1_en,
  input  logic [WIDTH-1:0] wr1_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic [AW-1:0]    wptr_nx;
  logic [CW-1:0]    n_wr;
  logic             rd;

  // Second write slot, push count and effective pop.
  always_comb begin
    wptr_nx = wptr_q + AW'(1);
    n_wr    = CW'(wr0_en) + CW'(wr1_en);
    rd      = rd_en && (cnt_q != '0);
  end

  // Pointer, occupancy and storage update; pointers wrap by width.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr0_en) mem_q[wptr_q]  <= wr0_data;
      if (wr1_en) mem_q[wptr_nx] <= wr1_data;
      wptr_q <= wptr_q + AW'(n_wr);
      rptr_q <= rptr_q + AW'(rd);
      cnt_q  <= cnt_q + n_wr - CW'(rd);
    end
  end

  assign rd_data = mem_q[rptr_q];
  assign count   = cnt_q;
  assign empty   = (cnt_q == '0);

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write-port controller: invalidate sweeps after reset and on flush,
// otherwise queues branch/jump updates and writes one per cycle.
module btb_update_ctrl #(
  parameter int WORD_SIZE = btb_pkg::WORD_SIZE,
  parameter int IDX_BITS  = btb_pkg::IDX_BITS,
  parameter int QDEPTH    = btb_pkg::QDEPTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      br_req,
  input  logic [WORD_SIZE-1:0]      br_pc,
  input  logic [WORD_SIZE-1:0]      br_target,
  input  logic                      br_taken,
  output logic                      br_ready,
  input  logic                      jmp_req,
  input  logic [WORD_SIZE-1:0]      jmp_pc,
  input  logic [WORD_SIZE-1:0]      jmp_target,
  output logic                      jmp_ready,
  input  logic                      flush_req,
  output logic                      btb_we,
  output logic [IDX_BITS-1:0]       btb_idx,
  output logic [WORD_SIZE-IDX_BITS-1:0] btb_tag,
  output logic [WORD_SIZE-1:0]      btb_target,
  output logic                      btb_valid,
  output logic                      btb_cnt_upd,
  output logic                      btb_cnt_taken,
  output logic                      busy
);

  import btb_pkg::*;

  localparam int TAG_W = WORD_SIZE - IDX_BITS;
  localparam int ENT_W = 2 * WORD_SIZE + 2;
  localparam int CNT_W = $clog2(QDEPTH) + 1;

  state_e              state_q, state_d;
  logic [IDX_BITS-1:0] sweep_q, sweep_d;

  logic             fifo_clr, fifo_rd_en, fifo_empty;
  logic             wr0_en, wr1_en;
  logic [ENT_W-1:0] wr0_data, wr1_data, br_ent, jmp_ent, head;
  logic [CNT_W-1:0] fifo_cnt, free;
  logic             run, br_acc, jmp_acc;

  logic [WORD_SIZE-1:0] head_pc, head_tgt;
  logic                 head_taken, head_isbr;

  btb_upd_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (fifo_clr),
    .wr0_en   (wr0_en),
    .wr0_data (wr0_data),
    .wr1_en   (wr1_en),
    .wr1_data (wr1_data),
    .rd_en    (fifo_rd_en),
    .rd_data  (head),
    .count    (fifo_cnt),
    .empty    (fifo_empty)
  );

  // State and sweep index registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Next state: sweeps end at the last index, flush restarts or enters a sweep.
  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    fifo_clr = 1'b0;
    case (state_q)
      ST_INIT, ST_FLUSH: begin
        if (flush_req) begin
          sweep_d = '0;
        end else if (sweep_q == '1) begin
          state_d = ST_RUN;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + IDX_BITS'(1);
        end
      end
      ST_RUN: begin
        if (flush_req) begin
          state_d  = ST_FLUSH;
          sweep_d  = '0;
          fifo_clr = 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
        sweep_d = '0;
      end
    endcase
  end

  // Request acceptance and enqueue ordering (branch ahead of jump).
  // Readies drop during a flush cycle so that cycle's requests are not taken.
  always_comb begin
    run       = (state_q == ST_RUN);
    free      = CNT_W'(QDEPTH) - fifo_cnt;
    br_ready  = run && !flush_req && (free >= CNT_W'(1));
    jmp_ready = run && !flush_req &&
                (br_req ? (free >= CNT_W'(2)) : (free >= CNT_W'(1)));
    br_acc    = br_req && br_ready;
    jmp_acc   = jmp_req && jmp_ready;
    br_ent    = {br_pc, br_target, br_taken, 1'b1};
    jmp_ent   = {jmp_pc, jmp_target, 1'b0, 1'b0};
    wr0_en    = br_acc || jmp_acc;
    wr0_data  = br_acc ? br_ent : jmp_ent;
    wr1_en    = br_acc && jmp_acc;
    wr1_data  = jmp_ent;
  end

  assign head_pc    = head[ENT_W-1 -: WORD_SIZE];
  assign head_tgt   = head[WORD_SIZE+1 -: WORD_SIZE];
  assign head_taken = head[1];
  assign head_isbr  = head[0];

  // BTB write port. Outputs are gated by reset_n so that nothing is written
  // while reset is held even though the sweep state is already INIT.
  always_comb begin
    busy          = is_sweep_state(state_q) || (state_q != ST_RUN);
    btb_we        = 1'b0;
    btb_idx       = '0;
    btb_tag       = '0;
    btb_target    = '0;
    btb_valid     = 1'b0;
    btb_cnt_upd   = 1'b0;
    btb_cnt_taken = 1'b0;
    fifo_rd_en    = 1'b0;
    if (reset_n && is_sweep_state(state_q)) begin
      btb_we      = 1'b1;
      btb_idx     = sweep_q;
      btb_cnt_upd = 1'b1;
    end else if (run && !flush_req && !fifo_empty) begin
      fifo_rd_en    = 1'b1;
      btb_we        = 1'b1;
      btb_valid     = 1'b1;
      btb_idx       = head_pc[IDX_BITS-1:0];
      btb_tag       = head_pc[WORD_SIZE-1 -: TAG_W];
      btb_target    = head_tgt;
      btb_cnt_upd   = head_isbr;
      btb_cnt_taken = head_isbr && head_taken;
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: sweeps, single/dual updates,
// backpressure ordering, flush with queued entries, reset mid-sweep.
module tb_btb_update_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        br_req, br_taken, jmp_req, flush_req;
  logic [15:0] br_pc, br_target, jmp_pc, jmp_target;
  logic        br_ready, jmp_ready;
  logic        btb_we, btb_valid, btb_cnt_upd, btb_cnt_taken, busy;
  logic [7:0]  btb_idx, btb_tag;
  logic [15:0] btb_target;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] tgt;
    logic        taken;
    logic        isbr;
  } ent_t;
  ent_t q[$];

  btb_update_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .br_req(br_req), .br_pc(br_pc), .br_target(br_target), .br_taken(br_taken),
    .br_ready(br_ready),
    .jmp_req(jmp_req), .jmp_pc(jmp_pc), .jmp_target(jmp_target), .jmp_ready(jmp_ready),
    .flush_req(flush_req),
    .btb_we(btb_we), .btb_idx(btb_idx), .btb_tag(btb_tag), .btb_target(btb_target),
    .btb_valid(btb_valid), .btb_cnt_upd(btb_cnt_upd), .btb_cnt_taken(btb_cnt_taken),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // {busy, br_ready, jmp_ready, we, valid, cnt_upd, cnt_taken, idx, tag, target}
  function automatic logic [38:0] obs();
    return {busy, br_ready, jmp_ready, btb_we, btb_valid, btb_cnt_upd, btb_cnt_taken,
            btb_idx, btb_tag, btb_target};
  endfunction

  function automatic logic [38:0] mk(input logic bsy, input logic br, input logic jr,
                                     input logic we, input logic v, input logic cu,
                                     input logic ct, input logic [7:0] idx,
                                     input logic [7:0] tag, input logic [15:0] tgt);
    return {bsy, br, jr, we, v, cu, ct, idx, tag, tgt};
  endfunction

  task automatic check(input string tag, input logic [38:0] o, input logic [38:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Check sweep writes start..stop; the first index is sampled at the current time.
  task automatic sweep_run(input int start, input int stop);
    for (int i = start; i <= stop; i++) begin
      if (i != start) begin
        @(negedge clk);
        #1;
      end
      check($sformatf("sweep_idx%0d", i), obs(),
            mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'(i), 8'h00, 16'h0000));
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    #1;
    check(tag, obs(), mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000));
  endtask

  initial begin
    int bcnt, jleft, jcnt, free;
    logic exp_br, exp_jr;
    ent_t e;

    reset_n = 1'b0;
    br_req = 0; br_taken = 0; jmp_req = 0; flush_req = 0;
    br_pc = '0; br_target = '0; jmp_pc = '0; jmp_target = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_hold", obs(), mk(1'b1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000));

    // Power-on sweep: first write right after release
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    sweep_run(0, 255);
    idle_check("init_done_idle");

    // Single taken branch
    @(negedge clk);
    br_req = 1; br_pc = 16'h1234; br_target = 16'h2000; br_taken = 1;
    #1;
    check("single_br_ready", obs(), mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000));
    @(negedge clk);
    br_req = 0;
    #1;
    check("single_br_write", obs(), mk(0, 1, 1, 1, 1, 1, 1, 8'h34, 8'h12, 16'h2000));
    @(negedge clk);
    #1;
    check("single_br_after", obs(), mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000));

    // Branch + jump same cycle
    @(negedge clk);
    br_req = 1; br_pc = 16'h4321; br_target = 16'h1111; br_taken = 0;
    jmp_req = 1; jmp_pc = 16'hABCD; jmp_target = 16'h5555;
    #1;
    check("dual_ready", obs(), mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000));
    @(negedge clk);
    br_req = 0; jmp_req = 0;
    #1;
    check("dual_br_write", obs(), mk(0, 1, 1, 1, 1, 1, 0, 8'h21, 8'h43, 16'h1111));
    @(negedge clk);
    #1;
    check("dual_jmp_write", obs(), mk(0, 1, 1, 1, 1, 0, 0, 8'hCD, 8'hAB, 16'h5555));
    @(negedge clk);
    #1;
    check("dual_after", obs(), mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000));

    // Backpressure: branch every cycle for 8 cycles, 3 jumps held until accepted
    bcnt = 0; jleft = 3; jcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      br_req = (c < 8);
      br_pc = 16'h1000 + 16'(bcnt); br_target = 16'h3000 + 16'(bcnt); br_taken = bcnt[0];
      jmp_req = (jleft > 0);
      jmp_pc = 16'h8000 + 16'(jcnt); jmp_target = 16'h0F00 + 16'(jcnt);
      #1;
      free = 4 - q.size();
      exp_br = (free >= 1);
      exp_jr = br_req ? (free >= 2) : (free >= 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check($sformatf("bp_write_c%0d", c), obs(),
              mk(0, exp_br, exp_jr, 1, 1, e.isbr, e.taken, e.pc[7:0], e.pc[15:8], e.tgt));
      end else begin
        check($sformatf("bp_idle_c%0d", c), obs(),
              mk(0, exp_br, exp_jr, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000));
      end
      if (br_req && exp_br) begin
        q.push_back('{br_pc, br_target, br_taken, 1'b1});
        bcnt++;
      end
      if (jmp_req && exp_jr) begin
        q.push_back('{jmp_pc, jmp_target, 1'b0, 1'b0});
        jleft--; jcnt++;
      end
    end
    br_req = 0; jmp_req = 0;

    // Flush with three entries queued
    @(negedge clk);
    br_req = 1; br_pc = 16'hA1A1; br_target = 16'h0101; br_taken = 1;
    jmp_req = 1; jmp_pc = 16'hB2B2; jmp_target = 16'h0202;
    @(negedge clk);
    br_pc = 16'hC3C3; br_target = 16'h0303; br_taken = 1;
    jmp_pc = 16'hD4D4; jmp_target = 16'h0404;
    #1;
    check("fl_first_write", obs(), mk(0, 1, 1, 1, 1, 1, 1, 8'hA1, 8'hA1, 16'h0101));
    @(negedge clk);
    flush_req = 1;
    br_pc = 16'hE5E5; jmp_pc = 16'hF6F6;
    #1;
    check("fl_cycle_nowrite", obs(), mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000));
    @(negedge clk);
    flush_req = 0; br_req = 0; jmp_req = 0;
    #1;
    sweep_run(0, 255);
    idle_check("flush_done_idle");

    // Flush during a sweep restarts at 0; then reset mid-sweep at index 100
    @(negedge clk);
    flush_req = 1;
    @(negedge clk);
    flush_req = 0;
    #1;
    sweep_run(0, 50);
    @(negedge clk);
    flush_req = 1;
    #1;
    sweep_run(51, 51);
    @(negedge clk);
    flush_req = 0;
    #1;
    sweep_run(0, 100);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", obs(), mk(1'b1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000));
    @(negedge clk);
    #1;
    check("reset_held", obs(), mk(1'b1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000));
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    sweep_run(0, 255);
    idle_check("resweep_done_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
